// File: rtl/count_monitor_pkg.sv
// Shared types and default parameters for the count_monitor observer.
package count_monitor_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } mon_state_t;

  localparam int unsigned W_DEF           = 8;
  localparam int unsigned ERR_W_DEF       = 8;
  localparam int unsigned SYNC_CYCLES_DEF = 2;

  // Width needed to hold a match count from 0 up to sync_cycles inclusive.
  function automatic int unsigned match_w(input int unsigned sync_cycles);
    return $clog2(sync_cycles + 1);
  endfunction

endpackage

// File: rtl/count_monitor_if.sv
// Observed counter stream: the enable fed to the counter and the counter value it produced.
interface count_monitor_if
  import count_monitor_pkg::*;
#(
  parameter int unsigned W = W_DEF
) ();

  logic         cnt_en;
  logic [W-1:0] count_in;

  modport master (output cnt_en, output count_in);
  modport slave  (input  cnt_en, input  count_in);

endinterface

// File: rtl/count_monitor_sat_counter.sv
// Saturating event counter: clears on reset or clr, increments on inc, holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] value_o
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = ZERO_VAL;
    end else if (inc_i && (value_q != MAX_VAL)) begin
      value_d = value_q + WIDTH'(1);
    end else begin
      value_d = value_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= ZERO_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/count_monitor.sv
// Observer for an enable-gated up-counter: locks onto the stream, flags mismatches and wraps.
// Define COUNT_MONITOR_STICKY_EN to latch a sticky fault on mismatch instead of relocking.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned W           = W_DEF,
  parameter int unsigned ERR_W       = ERR_W_DEF,
  parameter int unsigned SYNC_CYCLES = SYNC_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  count_monitor_if.slave   obs_if,
  output logic             locked_o,
  output logic             fault_o,
  output logic             err_pulse_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic             wrap_pulse_o,
  output logic [ERR_W-1:0] wrap_count_o
);

  localparam int unsigned MW = match_w(SYNC_CYCLES);

  mon_state_t    state_q,      state_d;
  logic          valid_q,      valid_d;
  logic [W-1:0]  prev_count_q, prev_count_d;
  logic          prev_en_q,    prev_en_d;
  logic [MW-1:0] match_cnt_q,  match_cnt_d;
  logic          locked_q,     locked_d;
  logic          fault_q,      fault_d;
  logic          err_pulse_q,  err_pulse_d;
  logic          wrap_pulse_q, wrap_pulse_d;

  logic [W-1:0]  exp_s;
  logic          match_s;
  logic          wrap_s;
  logic [MW-1:0] match_inc_s;
  logic          err_inc_s;
  logic          wrap_inc_s;

  // The counter applies its enable on the sampling edge, so its effect shows one sample later.
  assign exp_s       = prev_count_q + {{(W-1){1'b0}}, prev_en_q};
  assign match_s     = (obs_if.count_in == exp_s);
  assign wrap_s      = prev_en_q && (prev_count_q == {W{1'b1}}) && (obs_if.count_in == {W{1'b0}});
  assign match_inc_s = match_cnt_q + MW'(1);

  always_comb begin
    state_d      = state_q;
    valid_d      = 1'b1;
    prev_count_d = obs_if.count_in;
    prev_en_d    = obs_if.cnt_en;
    match_cnt_d  = match_cnt_q;
    locked_d     = locked_q;
    fault_d      = fault_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_inc_s    = 1'b0;
    wrap_inc_s   = 1'b0;
    if (clr_i) begin
      state_d      = UNSYNC;
      valid_d      = 1'b0;
      prev_count_d = {W{1'b0}};
      prev_en_d    = 1'b0;
      match_cnt_d  = {MW{1'b0}};
      locked_d     = 1'b0;
      fault_d      = 1'b0;
    end else begin
      case (state_q)
        UNSYNC: begin
          if (!valid_q) begin
            match_cnt_d = {MW{1'b0}};
          end else if (match_s) begin
            if (match_inc_s == MW'(SYNC_CYCLES)) begin
              state_d     = TRACK;
              locked_d    = 1'b1;
              match_cnt_d = {MW{1'b0}};
            end else begin
              match_cnt_d = match_inc_s;
            end
          end else begin
            match_cnt_d = {MW{1'b0}};
          end
        end
        TRACK: begin
          if (match_s) begin
            wrap_pulse_d = wrap_s;
            wrap_inc_s   = wrap_s;
          end else begin
            err_pulse_d = 1'b1;
            err_inc_s   = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = {MW{1'b0}};
`ifdef COUNT_MONITOR_STICKY_EN
            state_d     = FAULT;
            fault_d     = 1'b1;
`else
            state_d     = UNSYNC;
`endif
          end
        end
`ifdef COUNT_MONITOR_STICKY_EN
        // Parked until rst/clr; the stream is deliberately ignored here.
        FAULT: begin
          locked_d = 1'b0;
          fault_d  = 1'b1;
        end
`endif
        default: begin
          state_d     = UNSYNC;
          locked_d    = 1'b0;
          match_cnt_d = {MW{1'b0}};
        end
      endcase
    end
`ifndef COUNT_MONITOR_STICKY_EN
    fault_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= UNSYNC;
      valid_q      <= 1'b0;
      prev_count_q <= {W{1'b0}};
      prev_en_q    <= 1'b0;
      match_cnt_q  <= {MW{1'b0}};
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      prev_count_q <= prev_count_d;
      prev_en_q    <= prev_en_d;
      match_cnt_q  <= match_cnt_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .inc_i   (err_inc_s),
    .value_o (err_count_o)
  );

  sat_counter #(.WIDTH(ERR_W)) u_wrap_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .inc_i   (wrap_inc_s),
    .value_o (wrap_count_o)
  );

  assign locked_o     = locked_q;
  assign fault_o      = fault_q;
  assign err_pulse_o  = err_pulse_q;
  assign wrap_pulse_o = wrap_pulse_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed self-checking bench for count_monitor: lock, hold, wrap, mismatch, saturation, clr/rst.
module tb_count_monitor;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       locked;
  logic       fault;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic [7:0] x;
  int         total;
  int         bad;

  count_monitor_if #(.W(8)) bus ();

  count_monitor #(.W(8), .ERR_W(8), .SYNC_CYCLES(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (clr),
    .obs_if       (bus),
    .locked_o     (locked),
    .fault_o      (fault),
    .err_pulse_o  (err_pulse),
    .err_count_o  (err_count),
    .wrap_pulse_o (wrap_pulse),
    .wrap_count_o (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total = total + 1;
    assert (obs === expv) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic en, input logic [7:0] val);
    @(negedge clk);
    bus.cnt_en   = en;
    bus.count_in = val;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clr   = 1'b0;
    bus.cnt_en   = 1'b0;
    bus.count_in = 8'd0;
    x = 8'd0;

    // 1. reset
    step(1'b0, 8'd0);
    step(1'b0, 8'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_wrap_pulse", {31'd0, wrap_pulse}, 32'd0);
    chk("rst_wrap_count", {24'd0, wrap_count}, 32'd0);
    rst = 1'b0;
    step(1'b0, 8'd5);
    chk("first_sample_locked", {31'd0, locked}, 32'd0);

    // 2. hold-lock then enabled run
    step(1'b0, 8'd5);
    chk("second_sample_locked", {31'd0, locked}, 32'd0);
    step(1'b0, 8'd5);
    chk("third_sample_locked", {31'd0, locked}, 32'd1);
    for (int v = 5; v <= 14; v++) begin
      step(1'b1, 8'(v));
      chk("run_locked", {31'd0, locked}, 32'd1);
      chk("run_err_pulse", {31'd0, err_pulse}, 32'd0);
      chk("run_wrap_pulse", {31'd0, wrap_pulse}, 32'd0);
    end
    chk("run_err_count", {24'd0, err_count}, 32'd0);

    // 3. wrap
    clr = 1'b1;
    step(1'b1, 8'd0);
    chk("clr_locked", {31'd0, locked}, 32'd0);
    clr = 1'b0;
    step(1'b1, 8'd248);
    step(1'b1, 8'd249);
    step(1'b1, 8'd250);
    chk("wrap_pre_locked", {31'd0, locked}, 32'd1);
    for (int v = 251; v <= 255; v++) begin
      step(1'b1, 8'(v));
      chk("wrap_pre_pulse", {31'd0, wrap_pulse}, 32'd0);
    end
    step(1'b1, 8'd0);
    chk("wrap_pulse_hi", {31'd0, wrap_pulse}, 32'd1);
    chk("wrap_count_1", {24'd0, wrap_count}, 32'd1);
    chk("wrap_err_count", {24'd0, err_count}, 32'd0);
    step(1'b1, 8'd1);
    chk("wrap_pulse_lo", {31'd0, wrap_pulse}, 32'd0);
    chk("wrap_count_hold", {24'd0, wrap_count}, 32'd1);

    // 4. single mismatch 20 -> 22
    for (int v = 2; v <= 20; v++) begin
      step(1'b1, 8'(v));
    end
    chk("pre_err_locked", {31'd0, locked}, 32'd1);
    step(1'b1, 8'd22);
    chk("err_pulse_hi", {31'd0, err_pulse}, 32'd1);
    chk("err_count_1", {24'd0, err_count}, 32'd1);
    chk("err_unlocked", {31'd0, locked}, 32'd0);
`ifdef COUNT_MONITOR_STICKY_EN
    chk("fault_set", {31'd0, fault}, 32'd1);
    step(1'b1, 8'd23);
    chk("fault_err_pulse_lo", {31'd0, err_pulse}, 32'd0);
    chk("fault_hold", {31'd0, fault}, 32'd1);
    chk("fault_err_count", {24'd0, err_count}, 32'd1);
    step(1'b1, 8'd24);
    chk("fault_no_relock", {31'd0, locked}, 32'd0);
    chk("fault_still", {31'd0, fault}, 32'd1);
    clr = 1'b1;
    step(1'b1, 8'd0);
    chk("fault_clr", {31'd0, fault}, 32'd0);
    chk("fault_clr_err_count", {24'd0, err_count}, 32'd0);
    clr = 1'b0;
    step(1'b1, 8'd30);
    step(1'b1, 8'd31);
    step(1'b1, 8'd32);
    chk("fault_relock", {31'd0, locked}, 32'd1);
    chk("fault_relock_fault", {31'd0, fault}, 32'd0);
    x = 8'd32;
`else
    chk("no_fault", {31'd0, fault}, 32'd0);
    step(1'b1, 8'd23);
    chk("err_pulse_lo", {31'd0, err_pulse}, 32'd0);
    chk("relock_wait", {31'd0, locked}, 32'd0);
    step(1'b1, 8'd24);
    chk("relock", {31'd0, locked}, 32'd1);
    chk("relock_err_count", {24'd0, err_count}, 32'd1);
    chk("relock_wrap_count", {24'd0, wrap_count}, 32'd1);
    x = 8'd24;

    // 5. saturation: 300 mismatches, each followed by a two-sample relock
    for (int k = 0; k < 300; k++) begin
      step(1'b1, x + 8'd5);
      if (k == 0) chk("sat_first_pulse", {31'd0, err_pulse}, 32'd1);
      step(1'b1, x + 8'd6);
      step(1'b1, x + 8'd7);
      x = x + 8'd7;
      if (k == 99) chk("sat_mid_count", {24'd0, err_count}, 32'd101);
    end
    chk("sat_err_count", {24'd0, err_count}, 32'd255);
    chk("sat_wrap_count", {24'd0, wrap_count}, 32'd1);
    chk("sat_locked", {31'd0, locked}, 32'd1);
`endif

    // 6. clr coincident with mismatch, unsync wrap, rst mid-lock
    clr = 1'b1;
    step(1'b1, x + 8'd5);
    chk("clrmis_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("clrmis_err_count", {24'd0, err_count}, 32'd0);
    chk("clrmis_wrap_count", {24'd0, wrap_count}, 32'd0);
    chk("clrmis_locked", {31'd0, locked}, 32'd0);
    clr = 1'b0;
    step(1'b1, 8'd254);
    chk("unsync_load_locked", {31'd0, locked}, 32'd0);
    step(1'b1, 8'd255);
    chk("unsync_match1_locked", {31'd0, locked}, 32'd0);
    step(1'b1, 8'd0);
    chk("unsync_wrap_locks", {31'd0, locked}, 32'd1);
    chk("unsync_wrap_pulse", {31'd0, wrap_pulse}, 32'd0);
    chk("unsync_wrap_count", {24'd0, wrap_count}, 32'd0);
    step(1'b1, 8'd1);
    chk("post_unsync_locked", {31'd0, locked}, 32'd1);
    rst = 1'b1;
    step(1'b1, 8'd7);
    chk("midrst_locked", {31'd0, locked}, 32'd0);
    chk("midrst_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("midrst_err_count", {24'd0, err_count}, 32'd0);
    chk("midrst_wrap_count", {24'd0, wrap_count}, 32'd0);
    rst = 1'b0;
    step(1'b0, 8'd9);
    chk("post_rst_locked", {31'd0, locked}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
